// File: rtl/conv_tap_mac_pkg.sv
// rtl/conv_tap_mac_pkg.sv - shared constants, state encoding and width helpers for conv_tap_mac
// Purpose: default DATA_W/ACC_W/TAPS, FSM state enum, product and counter width helpers.
// Ports: none (package).
package conv_tap_mac_pkg;

    localparam int DEF_DATA_W = 3;
    localparam int DEF_ACC_W  = 10;
    localparam int DEF_TAPS   = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // PROD_W: an unsigned DATA_W x DATA_W product always fits in 2*DATA_W bits.
    function automatic int prod_width(input int data_w);
        return 2 * data_w;
    endfunction

    // CNT_W: wide enough to hold tap indices 0..TAPS-1, never narrower than 1 bit.
    function automatic int cnt_width(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/conv_tap_mac_shift_add_multiplier.sv
// rtl/conv_tap_mac_shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier
// Purpose: latches operands on start, then adds a<<k for each set bit b[k], one bit per cycle.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   start        load a/b, clear product, begin DATA_W-cycle multiply
//   a, b         unsigned operands (sampled only on start)
//   prod         running / final product (final once last has been seen)
//   last         high during the final multiply cycle (k == DATA_W-1)
module shift_add_multiplier
    import conv_tap_mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DATA_W-1:0]             a,
    input  logic [DATA_W-1:0]             b,
    output logic [prod_width(DATA_W)-1:0] prod,
    output logic                          last
);

    localparam int PROD_W = prod_width(DATA_W);
    localparam int K_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [K_W-1:0]    k;
    logic              busy;

    assign last = busy && (k == K_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            prod  <= '0;
            k     <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            a_reg <= a;
            b_reg <= b;
            prod  <= '0;
            k     <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            // Zero bits still consume their cycle so latency is operand-independent.
            if (b_reg[k]) begin
                prod <= prod + (PROD_W'(a_reg) << k);
            end
            k <= k + K_W'(1);
            if (last) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/conv_tap_mac.sv
// rtl/conv_tap_mac.sv - sequential multiply-accumulate over one convolution window
// Purpose: accepts TAPS (a, b) pairs, multiplies each by shift-and-add, accumulates modulo
//          2^ACC_W with a sticky wrap flag, and hands the window sum downstream.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    tap handshake; in_ready is high only in IDLE
//   in_a, in_b           unsigned activation / weight
//   out_valid/out_ready  window-sum handshake
//   out_sum              window sum modulo 2^ACC_W (0 when out_valid=0)
//   out_ovf              accumulator wrapped at least once in this window (0 when out_valid=0)
module conv_tap_mac
    import conv_tap_mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int TAPS   = DEF_TAPS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int PROD_W = prod_width(DATA_W);
    localparam int CNT_W  = cnt_width(TAPS);

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  tap_cnt;
    logic              ovf;

    logic              mul_start;
    logic              mul_last;
    logic [PROD_W-1:0] prod;
    logic [ACC_W:0]    acc_next;

    // in_ready is registered and mirrors state==IDLE, so this is in_valid & in_ready.
    assign mul_start = (state == IDLE) && in_valid;

    // One extra bit catches the carry out of the accumulator for the sticky wrap flag.
    assign acc_next = {1'b0, acc} + (ACC_W + 1)'(prod);

    shift_add_multiplier #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (in_a),
        .b     (in_b),
        .prod  (prod),
        .last  (mul_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            tap_cnt   <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= MUL;
                        in_ready <= 1'b0;
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc     <= acc_next[ACC_W-1:0];
                    tap_cnt <= tap_cnt + CNT_W'(1);
                    if (acc_next[ACC_W]) begin
                        ovf <= 1'b1;
                    end
                    if (tap_cnt == CNT_W'(TAPS - 1)) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_sum   <= acc_next[ACC_W-1:0];
                        out_ovf   <= ovf | acc_next[ACC_W];
                    end else begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        tap_cnt   <= '0;
                        ovf       <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_sum   <= '0;
                        out_ovf   <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_tap_mac.sv
// tb/tb_conv_tap_mac.sv - self-checking bench for conv_tap_mac (default and ACC_W=8 builds)
module tb_conv_tap_mac;

    localparam int DATA_W = 3;
    localparam int TAPS   = 9;
    localparam int LAT    = DATA_W + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              out_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;

    logic              in_ready;
    logic              out_valid;
    logic [9:0]        out_sum;
    logic              out_ovf;

    logic              in_ready8;
    logic              out_valid8;
    logic [7:0]        out_sum8;
    logic              out_ovf8;

    int     n_checks = 0;
    int     n_pass   = 0;
    longint model_total;
    int     wa[TAPS];
    int     wb[TAPS];

    always #5 clk = ~clk;

    conv_tap_mac dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    conv_tap_mac #(.ACC_W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready8),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .out_sum   (out_sum8),
        .out_ovf   (out_ovf8)
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_in_ready"},   in_ready,   1);
        check_eq({tag, "_in_ready8"},  in_ready8,  1);
        check_eq({tag, "_out_valid"},  out_valid,  0);
        check_eq({tag, "_out_valid8"}, out_valid8, 0);
        check_eq({tag, "_out_sum"},    out_sum,    0);
        check_eq({tag, "_out_sum8"},   out_sum8,   0);
        check_eq({tag, "_out_ovf"},    out_ovf,    0);
        check_eq({tag, "_out_ovf8"},   out_ovf8,   0);
    endtask

    // Called at a negedge; returns at a negedge after the tap has been clocked in.
    task automatic accept_tap(input int a, input int b);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check_eq("ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_a     = DATA_W'(a);
        in_b     = DATA_W'(b);
        @(negedge clk);
        in_valid = 1'b0;
        model_total += longint'(a) * longint'(b);
    endtask

    task automatic send_tap(input int a, input int b, input bit last);
        int lat = 0;
        accept_tap(a, b);
        // Busy period: throw garbage at the inputs, which must be ignored.
        while (!in_ready && !out_valid && lat < 50) begin
            lat++;
            in_valid = 1'($urandom_range(0, 1));
            in_a     = DATA_W'($urandom_range(0, 7));
            in_b     = DATA_W'($urandom_range(0, 7));
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq(last ? "busy_cycles_last" : "busy_cycles", lat, LAT);
        if (last) check_eq("out_valid_rise", out_valid, 1);
    endtask

    task automatic finish_window(input string tag, input int hold);
        longint e10 = model_total % 1024;
        longint e8  = model_total % 256;
        check_eq({tag, "_valid"},  out_valid,  1);
        check_eq({tag, "_valid8"}, out_valid8, 1);
        check_eq({tag, "_sum"},    out_sum,    e10);
        check_eq({tag, "_ovf"},    out_ovf,    (model_total >= 1024) ? 1 : 0);
        check_eq({tag, "_sum8"},   out_sum8,   e8);
        check_eq({tag, "_ovf8"},   out_ovf8,   (model_total >= 256) ? 1 : 0);
        check_eq({tag, "_busy"},   in_ready,   0);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, out_valid, 1);
            check_eq({tag, "_hold_sum"},   out_sum,   e10);
            check_eq({tag, "_hold_sum8"},  out_sum8,  e8);
            check_eq({tag, "_hold_ready"}, in_ready,  0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_idle_outputs({tag, "_after"});
        model_total = 0;
    endtask

    task automatic run_window(input string tag, input int hold);
        for (int i = 0; i < TAPS; i++) send_tap(wa[i], wb[i], i == TAPS - 1);
        finish_window(tag, hold);
    endtask

    task automatic fill(input int a, input int b);
        for (int i = 0; i < TAPS; i++) begin
            wa[i] = a;
            wb[i] = b;
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        out_ready   = 1'b1;
        model_total = 0;
        @(negedge clk);
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        fill(7, 7);
        run_window("w7x7", 0);
        fill(1, 1);
        run_window("w1x1", 0);
        fill(3, 5);
        run_window("w3x5", 0);
        fill(1, 2);
        run_window("w1x2", 0);

        for (int i = 0; i < TAPS; i++) begin
            wa[i] = $urandom_range(0, 7);
            wb[i] = $urandom_range(0, 7);
        end
        run_window("backpressure", 5);

        for (int i = 0; i < 3; i++) send_tap(4, 5, 1'b0);
        accept_tap(6, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_total = 0;
        check_idle_outputs("mid_reset");
        fill(2, 3);
        run_window("after_reset", 0);

        for (int i = 0; i < TAPS; i++) begin
            wa[i] = (i % 2 == 0) ? 0 : 7;
            wb[i] = (i % 2 == 0) ? 7 : 0;
        end
        run_window("zeros", 0);

        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < TAPS; i++) begin
                wa[i] = $urandom_range(0, 7);
                wb[i] = $urandom_range(0, 7);
            end
            run_window("random", $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_tap_mac.md
Name: conv_tap_mac

Overview:
- Sequential multiply-accumulate stage for one convolution window.
- Sits directly downstream of the small ripple-carry adder datapath. It consumes one (activation, weight) pair per tap and forms the product by shift-and-add over DATA_W cycles. It accumulates TAPS products and presents the window sum to the next stage through a valid/ready handshake.
- Default configuration is a 3x3 kernel (TAPS=9) with 3-bit unsigned operands.

Parameters:
- DATA_W, 3, unsigned operand width of in_a and in_b
- ACC_W, 10, accumulator / out_sum width; products are zero-extended to ACC_W
- TAPS, 9, number of products per window (must be >= 1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  tap operands valid
- in_ready  output  1  block can accept a tap (high only in IDLE)
- in_a  input  DATA_W  activation, unsigned
- in_b  input  DATA_W  weight, unsigned
- out_valid  output  1  window sum valid
- out_ready  input  1  downstream accepts sum
- out_sum  output  ACC_W  accumulated window sum, modulo 2^ACC_W
- out_ovf  output  1  sticky: accumulator wrapped at least once in this window

Behaviour:
- Reset: clk and rst are the only clocking controls; reset is synchronous and active-high. On reset the state becomes IDLE, accumulator, tap counter, product register, bit index and ovf are cleared, out_valid=0, out_sum=0, out_ovf=0, and in_ready=1 from the first cycle after reset. Reset overrides every other event, including mid-MUL and mid-OUT; any partial window is discarded.
- States: IDLE, MUL, ACC, OUT.
- IDLE: in_ready=1. When in_valid&in_ready, latch a_reg=in_a and b_reg=in_b, clear prod (width 2*DATA_W), set bit index k=0, and go to MUL.
- MUL: exactly DATA_W cycles. In each cycle, if b_reg[k], then prod += a_reg<<k; k++. After the cycle with k=DATA_W-1, go to ACC.
- ACC: one cycle. acc_next = acc + zero-extend(prod), computed at ACC_W+1 bits. acc takes the low ACC_W bits. If bit ACC_W is set, ovf is set (sticky). tap_cnt++. If tap_cnt was TAPS-1, go to OUT; otherwise go to IDLE.
- OUT: out_valid=1, out_sum=acc, out_ovf=ovf. These hold stable while out_ready=0. When out_valid&out_ready, clear acc, tap_cnt and ovf, and go to IDLE. in_ready=0 throughout OUT.
- Timing per tap: acceptance edge, then DATA_W MUL cycles, then one ACC cycle. in_ready returns DATA_W+1 cycles after the accepting cycle. Throughput is one tap per DATA_W+2 cycles.
- out_valid first rises in the cycle after the final ACC.
- out_sum and out_ovf are 0 whenever out_valid=0.
- Zero operands still take the full MUL duration; there is no early exit.
- in_a/in_b changes outside IDLE are ignored. in_valid while in_ready=0 is not consumed; upstream must hold its data.
- Product never overflows 2*DATA_W bits. Only the accumulator can wrap.

Decomposition:
- Shared package: default DATA_W, ACC_W and TAPS constants; state enum (IDLE, MUL, ACC, OUT); PROD_W = 2*DATA_W; CNT_W = clog2(TAPS).
- One natural sub-module: shift_add_multiplier (a_reg/b_reg/prod/k, with start and done signals). It is instantiated once, and the FSM and accumulator stay in conv_tap_mac.

Test Plan:
- Defaults; 9 taps of a=7, b=7, out_ready=1 -> out_sum=441, out_ovf=0; out_valid high exactly 1 cycle; in_ready low for 4 cycles after each accept.
- Defaults; 9 taps of a=3, b=5 -> out_sum=135. Then a second window of 9 taps a=1, b=2 -> out_sum=18, showing the accumulator cleared between windows.
- ACC_W=8 build; 9 taps of a=7, b=7 -> out_sum=185 (441 mod 256), out_ovf=1. The next window of 9 taps a=1, b=1 -> out_sum=9, out_ovf=0 (sticky cleared).
- Backpressure: after the window completes, hold out_ready=0 for 5 cycles -> out_valid and out_sum stay stable and in_ready=0; raise out_ready -> handshake completes and in_ready=1 on the next cycle.
- Reset mid-operation: assert rst for 1 cycle during MUL of tap 4 -> the next cycle shows IDLE, in_ready=1, out_valid=0. A fresh 9 taps a=2, b=3 -> out_sum=54.
- Zero/edge operands: 9 taps alternating a=0, b=7 and a=7, b=0 -> out_sum=0, and per-tap latency is unchanged (DATA_W+2 cycles).
